// File: rtl/predecode_stage.sv
// Pre-decode stage: 2-entry packet FIFO between Fetch and Decode with static direct-branch prediction.
// Optional macro PD_BTFN_EN: predict backward conditional branches taken (BTFN).
module predecode_stage #(
    parameter int FPD_W = 75,
    parameter int PDD_W = 107
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             FpD_valid,
    input  logic [FPD_W-1:0] FpD_BUS,
    output logic             pD_allowin,
    output logic [32:0]      predict_BUS,
    input  logic             flush,
    output logic             pDD_valid,
    output logic [PDD_W-1:0] pDD_BUS,
    input  logic             D_allowin
);

    typedef enum logic {S_RUN, S_SQUASH} state_t;

    state_t            state_q, state_d;
    logic [31:0]       wait_pc_q;
    logic [32:0]       predict_q;
    logic [1:0]        count_q;
    logic              wr_ptr_q, rd_ptr_q;
    logic [PDD_W-1:0]  mem_q [2];

    logic [31:0] in_pc, in_inst, off_b, off_c, pred_target;
    logic [7:0]  in_ecode;
    logic [5:0]  op;
    logic        in_ex, in_esub, pred_taken, accept, fire, enq, deq;
    logic        unused_req;
    logic [PDD_W-1:0] pkt_out;

    assign in_pc      = FpD_BUS[74:43];
    assign in_inst    = FpD_BUS[42:11];
    assign unused_req = FpD_BUS[10];
    assign in_ex      = FpD_BUS[9];
    assign in_ecode   = FpD_BUS[8:1];
    assign in_esub    = FpD_BUS[0];
    assign op         = in_inst[31:26];

    assign off_b = {{4{in_inst[9]}}, in_inst[9:0], in_inst[25:10], 2'b00};
    assign off_c = {{14{in_inst[25]}}, in_inst[25:10], 2'b00};

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = in_pc + 32'd4;
        case (op)
            6'b010100, 6'b010101: begin
                pred_taken  = 1'b1;
                pred_target = in_pc + off_b;
            end
            6'b010110, 6'b010111, 6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
`ifdef PD_BTFN_EN
                pred_taken  = in_inst[25];
                pred_target = in_pc + off_c;
`else
                pred_taken  = 1'b0;
`endif
            end
            default: pred_taken = 1'b0;
        endcase
        if (in_ex) pred_taken = 1'b0;
    end

    assign pkt_out = {in_pc, in_inst, pred_taken, pred_target, in_ex, in_ecode, in_esub};

    assign pD_allowin = (count_q != 2'd2);
    assign pDD_valid  = (count_q != 2'd0);
    assign pDD_BUS    = mem_q[rd_ptr_q];
    assign predict_BUS = predict_q;

    // Dropped wrong-path packets still handshake with Fetch (fire without enq).
    assign fire = FpD_valid & pD_allowin & ~flush;
    assign enq  = fire & accept;
    assign deq  = pDD_valid & D_allowin & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) state_q <= S_RUN;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (enq) state_d = pred_taken ? S_SQUASH : S_RUN;
    end

    always_comb begin
        accept = (state_q == S_RUN) || (in_pc == wait_pc_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_pc_q <= '0;
        end else if (enq && pred_taken) begin
            wait_pc_q <= pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush)          predict_q <= '0;
        else if (enq && pred_taken) predict_q <= {1'b1, pred_target};
        else                        predict_q <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (enq) wr_ptr_q <= ~wr_ptr_q;
            if (deq) rd_ptr_q <= ~rd_ptr_q;
            case ({enq, deq})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (enq) begin
            mem_q[wr_ptr_q] <= pkt_out;
        end
    end

endmodule

// File: tb/tb_predecode_stage.sv
// Directed self-checking bench for predecode_stage.
module tb_predecode_stage;

    logic          clk = 1'b0;
    logic          rst;
    logic          FpD_valid;
    logic [74:0]   FpD_BUS;
    logic          pD_allowin;
    logic [32:0]   predict_BUS;
    logic          flush;
    logic          pDD_valid;
    logic [106:0]  pDD_BUS;
    logic          D_allowin;

    int tests = 0;
    int failed = 0;

    localparam logic [31:0] NOP = 32'h0280_0000;
    localparam logic [31:0] B4  = 32'h5000_1000;   // B, offs26 = 4
    localparam logic [31:0] BLM = 32'h57FF_FBFF;   // BL, offs26 = -2
    localparam logic [31:0] BNE = 32'h5FFF_F000;   // BNE, offs16 = 0xFFFC

    predecode_stage dut (
        .clk(clk), .rst(rst), .FpD_valid(FpD_valid), .FpD_BUS(FpD_BUS),
        .pD_allowin(pD_allowin), .predict_BUS(predict_BUS), .flush(flush),
        .pDD_valid(pDD_valid), .pDD_BUS(pDD_BUS), .D_allowin(D_allowin)
    );

    always #5 clk = ~clk;

    function automatic logic [74:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                       input logic ex, input logic [7:0] ecode);
        return {pc, inst, 1'b1, ex, ecode, 1'b0};
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] inst);
        FpD_valid = 1'b1;
        FpD_BUS   = mk(pc, inst, 1'b0, 8'h00);
    endtask

    task automatic test_reset;
        rst = 1'b1; FpD_valid = 1'b0; FpD_BUS = '0; flush = 1'b0; D_allowin = 1'b1;
        cyc; cyc;
        tests++; if (pDD_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", pDD_valid); end
        tests++; if (pD_allowin !== 1'b1) begin failed++; $display("FAIL reset_allowin: got %b want 1", pD_allowin); end
        tests++; if (predict_BUS !== 33'b0) begin failed++; $display("FAIL reset_predict: got %h want 0", predict_BUS); end
        tests++; if (pDD_BUS !== 107'b0) begin failed++; $display("FAIL reset_bus: got %h want 0", pDD_BUS); end
        rst = 1'b0;
    endtask

    task automatic test_bypass;
        logic [31:0] pc;
        D_allowin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h1c00_0000 + 32'(4 * i);
            send(pc, NOP);
            cyc;
            tests++; if (pDD_valid !== 1'b1 || pDD_BUS[106:75] !== pc)
                begin failed++; $display("FAIL bypass_pc[%0d]: got v=%b pc=%h want v=1 pc=%h", i, pDD_valid, pDD_BUS[106:75], pc); end
            tests++; if (pDD_BUS[42] !== 1'b0 || pDD_BUS[41:10] !== pc + 32'd4)
                begin failed++; $display("FAIL bypass_pred[%0d]: got t=%b tgt=%h want t=0 tgt=%h", i, pDD_BUS[42], pDD_BUS[41:10], pc + 32'd4); end
            tests++; if (predict_BUS !== 33'b0) begin failed++; $display("FAIL bypass_predict[%0d]: got %h want 0", i, predict_BUS); end
        end
        FpD_valid = 1'b0;
        cyc;
        tests++; if (pDD_valid !== 1'b0) begin failed++; $display("FAIL bypass_drain: got %b want 0", pDD_valid); end
    endtask

    task automatic test_b_redirect;
        D_allowin = 1'b1;
        send(32'h1c00_0010, B4);
        cyc;
        tests++; if (predict_BUS !== {1'b1, 32'h1c00_0020}) begin failed++; $display("FAIL b_predict: got %h want %h", predict_BUS, {1'b1, 32'h1c00_0020}); end
        tests++; if (pDD_BUS[42] !== 1'b1 || pDD_BUS[41:10] !== 32'h1c00_0020)
            begin failed++; $display("FAIL b_pred_field: got t=%b tgt=%h want t=1 tgt=1c000020", pDD_BUS[42], pDD_BUS[41:10]); end
        send(32'h1c00_0014, NOP);
        cyc;
        tests++; if (predict_BUS !== 33'b0) begin failed++; $display("FAIL b_predict_pulse: got %h want 0", predict_BUS); end
        tests++; if (pDD_valid !== 1'b0) begin failed++; $display("FAIL b_squash_14: got %b want 0", pDD_valid); end
        send(32'h1c00_0018, NOP);
        cyc;
        tests++; if (pDD_valid !== 1'b0) begin failed++; $display("FAIL b_squash_18: got %b want 0", pDD_valid); end
        send(32'h1c00_0020, NOP);
        cyc;
        tests++; if (pDD_valid !== 1'b1 || pDD_BUS[106:75] !== 32'h1c00_0020)
            begin failed++; $display("FAIL b_target: got v=%b pc=%h want v=1 pc=1c000020", pDD_valid, pDD_BUS[106:75]); end
        send(32'h1c00_0024, NOP);
        cyc;
        tests++; if (pDD_valid !== 1'b1 || pDD_BUS[106:75] !== 32'h1c00_0024)
            begin failed++; $display("FAIL b_run: got v=%b pc=%h want v=1 pc=1c000024", pDD_valid, pDD_BUS[106:75]); end
        FpD_valid = 1'b0;
        cyc;
    endtask

    task automatic test_bl_backward;
        D_allowin = 1'b1;
        send(32'h1c00_0800, BLM);
        cyc;
        tests++; if (predict_BUS !== {1'b1, 32'h1c00_07f8}) begin failed++; $display("FAIL bl_predict: got %h want %h", predict_BUS, {1'b1, 32'h1c00_07f8}); end
        send(32'h1c00_0804, NOP);
        cyc;
        tests++; if (pDD_valid !== 1'b0) begin failed++; $display("FAIL bl_squash: got %b want 0", pDD_valid); end
        send(32'h1c00_07f8, NOP);
        cyc;
        tests++; if (pDD_valid !== 1'b1 || pDD_BUS[106:75] !== 32'h1c00_07f8)
            begin failed++; $display("FAIL bl_target: got v=%b pc=%h want v=1 pc=1c0007f8", pDD_valid, pDD_BUS[106:75]); end
        FpD_valid = 1'b0;
        cyc;
    endtask

    task automatic test_backpressure;
        D_allowin = 1'b0;
        send(32'h1c00_0200, NOP);
        cyc;
        tests++; if (pD_allowin !== 1'b1) begin failed++; $display("FAIL bp_allowin1: got %b want 1", pD_allowin); end
        send(32'h1c00_0204, NOP);
        cyc;
        tests++; if (pD_allowin !== 1'b0) begin failed++; $display("FAIL bp_allowin2: got %b want 0", pD_allowin); end
        send(32'h1c00_0208, NOP);
        cyc;
        tests++; if (pD_allowin !== 1'b0 || pDD_BUS[106:75] !== 32'h1c00_0200)
            begin failed++; $display("FAIL bp_hold: got allow=%b pc=%h want allow=0 pc=1c000200", pD_allowin, pDD_BUS[106:75]); end
        D_allowin = 1'b1;
        cyc;
        tests++; if (pDD_valid !== 1'b1 || pDD_BUS[106:75] !== 32'h1c00_0204 || pD_allowin !== 1'b1)
            begin failed++; $display("FAIL bp_drain1: got v=%b pc=%h allow=%b want v=1 pc=1c000204 allow=1", pDD_valid, pDD_BUS[106:75], pD_allowin); end
        cyc;
        tests++; if (pDD_valid !== 1'b1 || pDD_BUS[106:75] !== 32'h1c00_0208)
            begin failed++; $display("FAIL bp_drain2: got v=%b pc=%h want v=1 pc=1c000208", pDD_valid, pDD_BUS[106:75]); end
        FpD_valid = 1'b0;
        cyc;
        tests++; if (pDD_valid !== 1'b0) begin failed++; $display("FAIL bp_empty: got %b want 0", pDD_valid); end
    endtask

    task automatic test_bne;
        logic        exp_t;
        logic [31:0] exp_tgt;
`ifdef PD_BTFN_EN
        exp_t = 1'b1; exp_tgt = 32'h1c00_00f0;
`else
        exp_t = 1'b0; exp_tgt = 32'h1c00_0104;
`endif
        D_allowin = 1'b1;
        send(32'h1c00_0100, BNE);
        cyc;
        tests++; if (pDD_BUS[42] !== exp_t || pDD_BUS[41:10] !== exp_tgt)
            begin failed++; $display("FAIL bne_pred: got t=%b tgt=%h want t=%b tgt=%h", pDD_BUS[42], pDD_BUS[41:10], exp_t, exp_tgt); end
        tests++; if (predict_BUS !== (exp_t ? {1'b1, exp_tgt} : 33'b0))
            begin failed++; $display("FAIL bne_predict: got %h want t=%b", predict_BUS, exp_t); end
        send(32'h1c00_00f0, NOP);
        cyc;
        tests++; if (pDD_valid !== 1'b1 || pDD_BUS[106:75] !== 32'h1c00_00f0)
            begin failed++; $display("FAIL bne_next: got v=%b pc=%h want v=1 pc=1c0000f0", pDD_valid, pDD_BUS[106:75]); end
        FpD_valid = 1'b0;
        cyc;
    endtask

    task automatic test_flush_squash;
        D_allowin = 1'b0;
        send(32'h1c00_0300, NOP);
        cyc;
        send(32'h1c00_0304, B4);
        cyc;
        tests++; if (pD_allowin !== 1'b0 || predict_BUS !== {1'b1, 32'h1c00_0314})
            begin failed++; $display("FAIL fl_setup: got allow=%b pred=%h want allow=0 pred=%h", pD_allowin, predict_BUS, {1'b1, 32'h1c00_0314}); end
        flush = 1'b1;
        send(32'h1c00_0400, NOP);
        cyc;
        tests++; if (pDD_valid !== 1'b0 || pD_allowin !== 1'b1 || predict_BUS !== 33'b0)
            begin failed++; $display("FAIL fl_clear: got v=%b allow=%b pred=%h want v=0 allow=1 pred=0", pDD_valid, pD_allowin, predict_BUS); end
        flush = 1'b0;
        cyc;
        tests++; if (pDD_valid !== 1'b1 || pDD_BUS[106:75] !== 32'h1c00_0400)
            begin failed++; $display("FAIL fl_run: got v=%b pc=%h want v=1 pc=1c000400", pDD_valid, pDD_BUS[106:75]); end
        FpD_valid = 1'b0; D_allowin = 1'b1;
        cyc;
    endtask

    task automatic test_exception;
        D_allowin = 1'b1;
        FpD_valid = 1'b1;
        FpD_BUS   = mk(32'h1c00_0500, B4, 1'b1, 8'h08);
        cyc;
        tests++; if (pDD_BUS[42] !== 1'b0 || pDD_BUS[9] !== 1'b1 || pDD_BUS[8:1] !== 8'h08)
            begin failed++; $display("FAIL ex_fields: got t=%b ex=%b ecode=%h want t=0 ex=1 ecode=08", pDD_BUS[42], pDD_BUS[9], pDD_BUS[8:1]); end
        tests++; if (predict_BUS !== 33'b0) begin failed++; $display("FAIL ex_predict: got %h want 0", predict_BUS); end
        send(32'h1c00_0504, NOP);
        cyc;
        tests++; if (pDD_valid !== 1'b1 || pDD_BUS[106:75] !== 32'h1c00_0504)
            begin failed++; $display("FAIL ex_no_squash: got v=%b pc=%h want v=1 pc=1c000504", pDD_valid, pDD_BUS[106:75]); end
        FpD_valid = 1'b0;
        cyc;
    endtask

    task automatic test_mid_reset;
        D_allowin = 1'b0;
        send(32'h1c00_0600, B4);
        cyc;
        rst = 1'b1;
        send(32'h1c00_0700, NOP);
        cyc;
        tests++; if (pDD_valid !== 1'b0 || pD_allowin !== 1'b1 || predict_BUS !== 33'b0 || pDD_BUS !== 107'b0)
            begin failed++; $display("FAIL rst_mid: got v=%b allow=%b pred=%h bus=%h want all idle", pDD_valid, pD_allowin, predict_BUS, pDD_BUS); end
        rst = 1'b0;
        send(32'h1c00_0704, NOP);
        cyc;
        tests++; if (pDD_valid !== 1'b1 || pDD_BUS[106:75] !== 32'h1c00_0704)
            begin failed++; $display("FAIL rst_run: got v=%b pc=%h want v=1 pc=1c000704", pDD_valid, pDD_BUS[106:75]); end
        FpD_valid = 1'b0; D_allowin = 1'b1;
        cyc;
    endtask

    initial begin
        test_reset;
        test_bypass;
        test_b_redirect;
        test_bl_backward;
        test_backpressure;
        test_bne;
        test_flush_squash;
        test_exception;
        test_mid_reset;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
